mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_lat_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and default widths for the memory port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_default_aw = 16;
    localparam int c_default_dw = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_lat_counter.sv
// ============================================================================
// Module   : mem_arb_lat_counter
// Brief    : Load / decrement / zero-flag counter timing one memory access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_lat_counter #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] c_load_val = CW'(LATENCY - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported memory between IF and D ports with a
//            fixed multi-cycle access. Optional macro MEM_ARB_PERF_EN adds
//            stall/conflict performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int AW          = c_default_aw,
    parameter int DW          = c_default_dw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]   perf_if_wait,
    output logic [15:0]   perf_conflicts
`endif
);

    arb_state_t r_state;
    port_t      r_grant;
    port_t      r_last_grant;

    logic w_pend_if;
    logic w_pend_d;
    logic w_grant_d;
    logic w_load;
    logic w_dec;
    logic w_cnt_zero;

    assign w_pend_if = if_req;
    assign w_pend_d  = d_re | d_we;
    // Ties alternate: D wins unless it was the last port served.
    assign w_grant_d = w_pend_d & (~w_pend_if | (r_last_grant == PORT_IF));
    assign w_load    = (r_state == IDLE) & (w_pend_if | w_pend_d);
    assign w_dec     = (r_state == BUSY) & ~w_cnt_zero;

    assign if_stall = if_req & ~if_done;
    assign d_stall  = w_pend_d & ~d_done;

    mem_arb_lat_counter #(
        .LATENCY (MEM_LATENCY)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= PORT_IF;
            r_last_grant <= PORT_IF;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pend_if || w_pend_d) begin
                        mem_en  <= 1'b1;
                        r_state <= BUSY;
                        if (w_grant_d) begin
                            r_grant      <= PORT_D;
                            r_last_grant <= PORT_D;
                            mem_addr     <= d_addr;
                            mem_wdata    <= d_wdata;
                            mem_we       <= d_we;
                        end else begin
                            r_grant      <= PORT_IF;
                            r_last_grant <= PORT_IF;
                            mem_addr     <= if_addr;
                            mem_we       <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (w_cnt_zero) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        r_state <= RESP;
                        if (r_grant == PORT_IF) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_wait   <= '0;
            perf_conflicts <= '0;
        end else begin
            if (if_stall && (perf_if_wait != 16'hFFFF)) begin
                perf_if_wait <= perf_if_wait + 16'd1;
            end
            if ((r_state == IDLE) && w_pend_if && w_pend_d && (perf_conflicts != 16'hFFFF)) begin
                perf_conflicts <= perf_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and randomized checks of mem_port_arbiter against a
//            transaction-timing reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_re, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, if_stall, d_done, d_stall, mem_en, mem_we;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_if_wait, perf_conflicts;
`endif

    logic [15:0] macro_mem [16];
    logic [15:0] ref_mem   [16];

    always #5 clk = ~clk;

    assign mem_rdata = mem_en ? macro_mem[mem_addr[3:0]] : 16'h0000;

    mem_port_arbiter #(
        .MEM_LATENCY (L),
        .AW          (16),
        .DW          (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_done        (if_done),
        .if_stall       (if_stall),
        .d_re           (d_re),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_done         (d_done),
        .d_stall        (d_stall),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_wait   (perf_if_wait),
        .perf_conflicts (perf_conflicts)
`endif
    );

    // Reference model: an access sampled in cycle g occupies the memory in
    // cycles g+1..g+L, completes in g+L+1, and the next grant is sampled no
    // earlier than g+L+2.
    int          cyc, free_at, g;
    int          errors, checks;
    bit          active, g_d, g_we, last_d, chk_on, after_rst;
    logic [15:0] g_addr, g_wdata, g_data;
    logic [15:0] exp_if_rdata, exp_d_rdata, exp_wait, exp_conf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        bit e_en, e_ifd, e_dd, pend_d;
        e_en   = active && (cyc >= g + 1) && (cyc <= g + L);
        e_ifd  = active && !g_d && (cyc == g + L + 1);
        e_dd   = active && g_d && (cyc == g + L + 1);
        pend_d = d_re | d_we;
        if (e_ifd) exp_if_rdata = g_data;
        if (e_dd && !g_we) exp_d_rdata = g_data;

        @(negedge clk);
        if (chk_on) begin
            check("mem_en", 32'(mem_en), 32'(e_en));
            check("mem_we", 32'(mem_we), 32'(e_en && g_we));
            if (e_en) begin
                check("mem_addr", 32'(mem_addr), 32'(g_addr));
                if (g_we) check("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
            end
            check("if_done", 32'(if_done), 32'(e_ifd));
            check("d_done", 32'(d_done), 32'(e_dd));
            check("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
            check("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
            check("if_stall", 32'(if_stall), 32'(if_req && !e_ifd));
            check("d_stall", 32'(d_stall), 32'(pend_d && !e_dd));
            if (after_rst) begin
                check("rst_mem_addr", 32'(mem_addr), 32'h0);
                check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
            end
`ifdef MEM_ARB_PERF_EN
            check("perf_if_wait", 32'(perf_if_wait), 32'(exp_wait));
            check("perf_conflicts", 32'(perf_conflicts), 32'(exp_conf));
`endif
        end
        if (mem_en && mem_we) macro_mem[mem_addr[3:0]] = mem_wdata;

        @(posedge clk);
        #1;
        after_rst = rst;
        if (rst) begin
            active       = 1'b0;
            last_d       = 1'b0;
            exp_if_rdata = 16'h0;
            exp_d_rdata  = 16'h0;
            exp_wait     = 16'h0;
            exp_conf     = 16'h0;
            free_at      = cyc + 1;
            chk_on       = 1'b1;
        end else begin
            if (if_req && !e_ifd && exp_wait != 16'hFFFF) exp_wait = exp_wait + 16'd1;
            if (cyc >= free_at && if_req && pend_d && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
            if (active && cyc == g + L + 1) active = 1'b0;
            if (cyc >= free_at && (if_req || pend_d)) begin
                g_d     = pend_d && (!if_req || !last_d);
                last_d  = g_d;
                g       = cyc;
                free_at = cyc + L + 2;
                active  = 1'b1;
                g_addr  = g_d ? d_addr : if_addr;
                g_we    = g_d && d_we;
                g_wdata = d_wdata;
                if (g_we) ref_mem[g_addr[3:0]] = d_wdata;
                g_data  = ref_mem[g_addr[3:0]];
            end
        end
        cyc++;
    endtask

    task automatic init_mems();
        for (int i = 0; i < 16; i++) begin
            macro_mem[i] = 16'($urandom);
            ref_mem[i]   = macro_mem[i];
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        cyc = 0; free_at = 0; g = 0; errors = 0; checks = 0;
        active = 1'b0; g_d = 1'b0; g_we = 1'b0; last_d = 1'b0;
        chk_on = 1'b0; after_rst = 1'b0;
        g_addr = '0; g_wdata = '0; g_data = '0;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_wait = '0; exp_conf = '0;
        init_mems();
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Reset while a write is in flight
        d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hA5A5;
        run_cycle();
        run_cycle();
        d_we = 1'b0; rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        repeat (7) run_cycle();
        init_mems();

        // Single IF read
        macro_mem[0] = 16'hBEEF; ref_mem[0] = 16'hBEEF;
        if_req = 1'b1; if_addr = 16'h0040;
        repeat (6) run_cycle();
        if_req = 1'b0;
        repeat (2) run_cycle();

        // D write
        d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        repeat (6) run_cycle();
        d_we = 1'b0;
        repeat (2) run_cycle();

        // Tie after reset goes to D, then IF; a repeated tie goes to D again
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if_req = 1'b1; if_addr = 16'h0040; d_re = 1'b1; d_addr = 16'h0003;
            repeat (6) run_cycle();
            d_re = 1'b0;
            repeat (6) run_cycle();
            if_req = 1'b0;
            run_cycle();
        end

        // D read withdrawn mid-access
        d_re = 1'b1; d_addr = 16'h0007;
        repeat (2) run_cycle();
        d_re = 1'b0;
        repeat (6) run_cycle();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) if_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                d_re = 1'($urandom_range(0, 1));
                d_we = ($urandom_range(0, 2) == 0);
            end
            if_addr = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
            run_cycle();
        end
        if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
        repeat (8) run_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
